// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: sequential imem reads into a DEPTH-entry prefetch FIFO toward decode.
// Zero-latency request, push visible one cycle later; redirect flushes, halt stops issuing but drains.
module fetch_prefetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  output logic                     imem_we_re,
  output logic [3:0]               imem_mask,
  input  logic                     imem_valid,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_addr,
  input  logic                     halt_req,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst_data,
  output logic [XLEN-1:0]          inst_pc,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     misaligned,
  output logic                     halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            misaligned_q, misaligned_d;

  logic [31:0]     buf_dat_q [DEPTH];
  logic [XLEN-1:0] buf_pc_q  [DEPTH];

  logic run;
  logic push;
  logic pop;
  logic head_vld;
  logic target_mis;

  assign run        = (state_q == ST_RUN);
  assign head_vld   = (count_q != '0);
  assign target_mis = (redirect_addr[1:0] != 2'b00);

  // Request ignores inst_ready on purpose: a full FIFO stalls even when popping.
  assign imem_req   = run && (count_q < DEPTH_C) && !redirect_valid && !halt_req;
  assign push       = imem_req && imem_valid;
  assign inst_valid = head_vld && !redirect_valid;
  assign pop        = inst_valid && inst_ready;

  assign imem_addr  = fetch_pc_q;
  assign imem_we_re = 1'b0;
  assign imem_mask  = 4'hF;
  assign inst_data  = buf_dat_q[rd_ptr_q];
  assign inst_pc    = buf_pc_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign misaligned = misaligned_q;
  assign halted     = (state_q == ST_HALTED);

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    misaligned_d = misaligned_q;

    if (redirect_valid) begin
      // Flush wins over any transfer or pop happening in the same cycle.
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      fetch_pc_d   = redirect_addr;
      misaligned_d = target_mis;
      state_d      = target_mis ? ST_HALTED : ST_RUN;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + AW'(1);
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);

      case (state_q)
        ST_BOOT:   state_d = ST_RUN;
        ST_RUN:    if (halt_req) state_d = ST_HALTED;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      fetch_pc_q   <= RESET_PC;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      buf_dat_q[wr_ptr_q] <= imem_rdata;
      buf_pc_q[wr_ptr_q]  <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: queue-based reference model, directed scenarios then random traffic.
module tb_fetch_prefetch_unit;

  localparam int TB_DEPTH = 4;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut0: RESET_PC = 0, checked cycle by cycle against the model
  logic        rst0, rv0, hr0, iv0, ir0;
  logic [31:0] ra0, rdata0, addr0, ipc0, idat0;
  logic        req0, we0, ivld0, mis0, hlt0;
  logic [3:0]  mask0;
  logic [2:0]  cnt0;

  // dut1: RESET_PC near the top of the address space
  logic        rst1, iv1, ir1;
  logic [31:0] rdata1, addr1, ipc1, idat1;
  logic        req1, we1, ivld1, mis1, hlt1;
  logic [3:0]  mask1;
  logic [2:0]  cnt1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0123_4567;
  endfunction

  assign rdata0 = memf(addr0);
  assign rdata1 = memf(addr1);

  fetch_prefetch_unit #(.XLEN(32), .DEPTH(TB_DEPTH), .RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst0), .imem_req(req0), .imem_addr(addr0), .imem_we_re(we0),
    .imem_mask(mask0), .imem_valid(iv0), .imem_rdata(rdata0), .redirect_valid(rv0),
    .redirect_addr(ra0), .halt_req(hr0), .inst_valid(ivld0), .inst_ready(ir0),
    .inst_data(idat0), .inst_pc(ipc0), .fifo_count(cnt0), .misaligned(mis0), .halted(hlt0)
  );

  fetch_prefetch_unit #(.XLEN(32), .DEPTH(TB_DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .rst(rst1), .imem_req(req1), .imem_addr(addr1), .imem_we_re(we1),
    .imem_mask(mask1), .imem_valid(iv1), .imem_rdata(rdata1), .redirect_valid(1'b0),
    .redirect_addr(32'h0), .halt_req(1'b0), .inst_valid(ivld1), .inst_ready(ir1),
    .inst_data(idat1), .inst_pc(ipc1), .fifo_count(cnt1), .misaligned(mis1), .halted(hlt1)
  );

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: a queue of (pc, word) pairs plus the architectural fetch state.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] dat;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_boot, m_halt, m_mis, m_valid;

  initial m_valid = 1'b0;

  task automatic cyc(input logic r, input logic rv, input logic [31:0] ra,
                     input logic hr, input logic iv, input logic ir);
    bit   running, e_req, e_iv;
    ent_t e;
    rst0 = r; rv0 = rv; ra0 = ra; hr0 = hr; iv0 = iv; ir0 = ir;
    #1;
    if (m_valid) begin
      running = !m_boot && !m_halt;
      e_req   = running && (mq.size() < TB_DEPTH) && !rv && !hr;
      e_iv    = (mq.size() != 0) && !rv;
      chk("imem_req", 64'(req0), 64'(e_req));
      chk("imem_addr", 64'(addr0), 64'(m_pc));
      chk("fifo_count", 64'(cnt0), 64'(mq.size()));
      chk("inst_valid", 64'(ivld0), 64'(e_iv));
      chk("misaligned", 64'(mis0), 64'(m_mis));
      chk("halted", 64'(hlt0), 64'(m_halt));
      chk("we_mask", {59'd0, we0, mask0}, 64'h0F);
      if (e_iv) begin
        chk("inst_pc", 64'(ipc0), 64'(mq[0].pc));
        chk("inst_data", 64'(idat0), 64'(mq[0].dat));
      end
      if (!r) begin
        if (rv) begin
          mq.delete();
          m_pc   = ra;
          m_mis  = (ra[1:0] != 2'b00);
          m_halt = m_mis;
          m_boot = 1'b0;
        end else begin
          if (e_iv && ir) void'(mq.pop_front());
          if (e_req && iv) begin
            e.pc  = m_pc;
            e.dat = memf(m_pc);
            mq.push_back(e);
            m_pc = m_pc + 32'd4;
          end
          if (running && hr) m_halt = 1'b1;
          m_boot = 1'b0;
        end
      end
    end
    if (r) begin
      mq.delete();
      m_pc    = 32'h0;
      m_boot  = 1'b1;
      m_halt  = 1'b0;
      m_mis   = 1'b0;
      m_valid = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ra_r;
    logic        rv_r;
    rst0 = 1'b1; rv0 = 1'b0; ra0 = '0; hr0 = 1'b0; iv0 = 1'b0; ir0 = 1'b0;
    rst1 = 1'b1; iv1 = 1'b0; ir1 = 1'b0;

    // T6 on dut1 while dut0 sits in reset
    @(negedge clk);
    @(negedge clk);
    rst1 = 1'b0; iv1 = 1'b1; ir1 = 1'b1;
    #1;
    chk("t6_boot_req", 64'(req1), 64'd0);
    chk("t6_boot_addr", 64'(addr1), 64'hFFFF_FFF8);
    chk("t6_boot_cnt", 64'(cnt1), 64'd0);
    chk("t6_boot_ivld", 64'(ivld1), 64'd0);
    chk("t6_boot_hlt", {62'd0, hlt1, mis1}, 64'd0);
    @(negedge clk); #1;
    chk("t6_req_f8", 64'(req1), 64'd1);
    chk("t6_addr_f8", 64'(addr1), 64'hFFFF_FFF8);
    @(negedge clk); #1;
    chk("t6_addr_fc", 64'(addr1), 64'hFFFF_FFFC);
    chk("t6_ivld_f8", 64'(ivld1), 64'd1);
    chk("t6_pc_f8", 64'(ipc1), 64'hFFFF_FFF8);
    chk("t6_dat_f8", 64'(idat1), 64'(memf(32'hFFFF_FFF8)));
    @(negedge clk); #1;
    chk("t6_addr_wrap", 64'(addr1), 64'h0);
    chk("t6_pc_fc", 64'(ipc1), 64'hFFFF_FFFC);
    @(negedge clk);
    iv1 = 1'b0;
    #1;
    chk("t6_addr_4", 64'(addr1), 64'h4);
    chk("t6_pc_0", 64'(ipc1), 64'h0);
    @(negedge clk); #1;
    chk("t6_wait_addr", 64'(addr1), 64'h4);
    chk("t6_wait_req", 64'(req1), 64'd1);
    chk("t6_wait_cnt", 64'(cnt1), 64'd0);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    #1;
    chk("t6_rst_req", 64'(req1), 64'd0);
    chk("t6_rst_cnt", 64'(cnt1), 64'd0);
    chk("t6_rst_addr", 64'(addr1), 64'hFFFF_FFF8);
    chk("t6_rst_ivld", 64'(ivld1), 64'd0);

    // T1: reset, then free-running fetch with decode always ready
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 0, 1, 1);
    // T2: stall decode until full, then drain
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 0, 1, 0);
    chk("t2_full", 64'(cnt0), 64'd4);
    chk("t2_full_req", 64'(req0), 64'd0);
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 0, 1, 1);
    // T3: wait states
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1, 1);
    // T4: redirect with three entries buffered and a transfer offered
    for (int k = 0; k < 20 && cnt0 != 3'd3; k++) cyc(0, 0, 0, 0, 1, 0);
    chk("t4_cnt3", 64'(cnt0), 64'd3);
    cyc(0, 1, 32'h100, 0, 1, 1);
    chk("t4_flush", 64'(cnt0), 64'd0);
    chk("t4_addr", 64'(addr0), 64'h100);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 1, 1);
    // T5: misaligned redirect, recovery, then halt with drain
    cyc(0, 1, 32'h102, 0, 1, 1);
    chk("t5_mis", 64'(mis0), 64'd1);
    chk("t5_hlt", 64'(hlt0), 64'd1);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 1, 1);
    cyc(0, 1, 32'h200, 0, 1, 0);
    chk("t5_mis_clr", 64'(mis0), 64'd0);
    chk("t5_addr", 64'(addr0), 64'h200);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 1, 1, 1);
    chk("t5_drained", 64'(cnt0), 64'd0);
    cyc(0, 1, 32'h300, 0, 1, 1);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      ra_r = $urandom;
      if ($urandom_range(0, 3) != 0) ra_r[1:0] = 2'b00;
      rv_r = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      cyc($urandom_range(0, 299) == 0, rv_r, ra_r, $urandom_range(0, 19) == 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
